// File: rtl/axil_wr_arbiter.sv
// Two-master to one-slave AXI-lite write arbiter (AW/W/B), whole-transaction grants.
// Round-robin by default; define AXIL_WR_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins).
module axil_wr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    axi_rst,
  input  logic [2*ADDR_WIDTH-1:0] m_awaddr,
  input  logic [1:0]              m_awvalid,
  output logic [1:0]              m_awready,
  input  logic [2*DATA_WIDTH-1:0] m_wdata,
  input  logic [2*STRB_WIDTH-1:0] m_wstrb,
  input  logic [1:0]              m_wvalid,
  output logic [1:0]              m_wready,
  output logic [1:0]              m_bvalid,
  input  logic [1:0]              m_bready,
  output logic [ADDR_WIDTH-1:0]   s_awaddr,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [STRB_WIDTH-1:0]   s_wstrb,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  output logic [1:0]              grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       aw_hs, w_hs;
  logic       owner;

`ifdef AXIL_WR_ARB_FIXED_PRIO_EN
`else
  logic       last_q, last_d;
`endif

  assign owner = grant_q[1];
  assign grant = grant_q;

  // State register
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef AXIL_WR_ARB_FIXED_PRIO_EN
`else
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef AXIL_WR_ARB_FIXED_PRIO_EN
`else
      last_q    <= last_d;
`endif
    end
  end

  // Next-state and channel routing
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef AXIL_WR_ARB_FIXED_PRIO_EN
`else
    last_d    = last_q;
`endif
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    m_awready = 2'b00;
    m_wready  = 2'b00;
    m_bvalid  = 2'b00;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    s_awaddr  = owner ? m_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_awaddr[ADDR_WIDTH-1:0];
    s_wdata   = owner ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
    s_wstrb   = owner ? m_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : m_wstrb[STRB_WIDTH-1:0];

    case (state_q)
      IDLE: begin
        // Arbitrate on AW valid only; W-only requesters wait.
        case (m_awvalid)
          2'b01: begin
            grant_d = 2'b01;
            state_d = XFER;
          end
          2'b10: begin
            grant_d = 2'b10;
            state_d = XFER;
          end
          2'b11: begin
`ifdef AXIL_WR_ARB_FIXED_PRIO_EN
            grant_d = 2'b01;
`else
            grant_d = last_q ? 2'b01 : 2'b10;
`endif
            state_d = XFER;
          end
          default: begin
            grant_d = 2'b00;
          end
        endcase
      end

      XFER: begin
        s_awvalid = m_awvalid[owner] & ~aw_done_q;
        s_wvalid  = m_wvalid[owner] & ~w_done_q;
        m_awready = grant_q & {2{s_awready & ~aw_done_q}};
        m_wready  = grant_q & {2{s_wready & ~w_done_q}};
        aw_hs     = s_awvalid & s_awready;
        w_hs      = s_wvalid & s_wready;
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d   = RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end

      RESP: begin
        m_bvalid = grant_q & {2{s_bvalid}};
        s_bready = m_bready[owner];
        if (s_bvalid & s_bready) begin
          state_d = IDLE;
          grant_d = 2'b00;
`ifdef AXIL_WR_ARB_FIXED_PRIO_EN
`else
          last_d  = owner;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase

    // Keep every handshake output quiet while reset is asserted.
    if (axi_rst) begin
      m_awready = 2'b00;
      m_wready  = 2'b00;
      m_bvalid  = 2'b00;
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      s_bready  = 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Randomized self-checking bench for axil_wr_arbiter with transaction-level masters, slave and arbitration model.
module tb_axil_wr_arbiter;
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic            clk = 1'b0;
  logic            axi_rst;
  logic [2*AW-1:0] m_awaddr;
  logic [1:0]      m_awvalid, m_awready;
  logic [2*DW-1:0] m_wdata;
  logic [2*SW-1:0] m_wstrb;
  logic [1:0]      m_wvalid, m_wready, m_bvalid, m_bready;
  logic [AW-1:0]   s_awaddr;
  logic            s_awvalid, s_awready;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic            s_wvalid, s_wready, s_bvalid, s_bready;
  logic [1:0]      grant;

  axil_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .axi_rst(axi_rst),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [1:0]    dly;
  } txn_t;

  txn_t          txq [2][$];
  logic [AW-1:0] slv_log [$];
  logic [AW-1:0] exp_ord [4];
  int  checks = 0;
  int  failures = 0;
  bit  aw_sent [2];
  bit  w_sent [2];
  int  age [2];
  int  bst [2];
  int  bcnt [2];
  int  pushed [2];
  int  bv_cyc [2];
  bit  brand, srand, rand_bdly, rst_req;
  int  aw_stall, w_stall, bdelay, b_cnt;
  bit  has_aw, has_w, b_pend;
  int  aw_rel, w_rel, whs_cnt, xcyc, bv0, whs0;
  bit  model_busy, model_owner, model_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic [1:0] dl);
    txn_t t;
    t.addr = a;
    t.data = d;
    t.strb = s;
    t.dly  = dl;
    txq[i].push_back(t);
    pushed[i]++;
  endtask

  // Drive masters and slave from their behavioural state.
  task automatic drive();
    axi_rst = rst_req;
    for (int i = 0; i < 2; i++) begin
      if (txq[i].size() > 0) begin
        m_awaddr[i*AW +: AW] = txq[i][0].addr;
        m_wdata[i*DW +: DW]  = txq[i][0].data;
        m_wstrb[i*SW +: SW]  = txq[i][0].strb;
        m_awvalid[i] = !aw_sent[i] && (age[i] >= int'(txq[i][0].dly));
        m_wvalid[i]  = !w_sent[i];
      end else begin
        m_awvalid[i] = 1'b0;
        m_wvalid[i]  = 1'b0;
      end
      m_bready[i] = (bst[i] == 0) && (!brand || $urandom_range(0, 1) == 1);
    end
    s_awready = (aw_stall == 0) && (!srand || $urandom_range(0, 1) == 1);
    s_wready  = (w_stall == 0) && (!srand || $urandom_range(0, 1) == 1);
    s_bvalid  = b_pend && (b_cnt == 0);
  endtask

  // Check outputs against the model, then advance masters, slave and arbitration model.
  task automatic monitor();
    logic [1:0] gexp;
    bit own, aw_hs, w_hs, b_hs;
    if (model_busy) xcyc++;
    own  = model_owner;
    gexp = model_busy ? (own ? 2'b10 : 2'b01) : 2'b00;
    check("grant", 64'(grant), 64'(gexp));
    check("nonowner_quiet", 64'((m_awready | m_wready | m_bvalid) & ~gexp), 64'(0));
    if (axi_rst || !model_busy) begin
      check("idle_quiet", 64'({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}), 64'(0));
    end else begin
      check("s_awvalid", 64'(s_awvalid), 64'(!has_aw && m_awvalid[own]));
      check("s_wvalid", 64'(s_wvalid), 64'(!has_w && m_wvalid[own]));
      check("m_awready", 64'(m_awready[own]), 64'(s_awready && !has_aw));
      check("m_wready", 64'(m_wready[own]), 64'(s_wready && !has_w));
      check("m_bvalid", 64'(m_bvalid[own]), 64'(s_bvalid));
      check("s_bready", 64'(s_bready), 64'(b_pend && m_bready[own]));
    end

    aw_hs = s_awvalid && s_awready;
    w_hs  = s_wvalid && s_wready;
    b_hs  = s_bvalid && s_bready;
    if (aw_hs) begin
      check("aw_has_txn", 64'(txq[own].size() > 0), 64'(1));
      if (txq[own].size() > 0) check("s_awaddr", 64'(s_awaddr), 64'(txq[own][0].addr));
      slv_log.push_back(s_awaddr);
      has_aw = 1'b1;
      aw_rel = xcyc;
    end
    if (w_hs) begin
      if (txq[own].size() > 0) begin
        check("s_wdata", 64'(s_wdata), 64'(txq[own][0].data));
        check("s_wstrb", 64'(s_wstrb), 64'(txq[own][0].strb));
      end
      has_w = 1'b1;
      w_rel = xcyc;
      whs_cnt++;
    end

    for (int i = 0; i < 2; i++) begin
      if (m_bvalid[i]) bv_cyc[i]++;
      if (m_bvalid[i] && bst[i] > 0) bst[i]--;
      if (m_awvalid[i] && m_awready[i]) aw_sent[i] = 1'b1;
      if (m_wvalid[i] && m_wready[i]) w_sent[i] = 1'b1;
      if (m_bvalid[i] && m_bready[i]) begin
        check("b_after_aw_w", 64'(aw_sent[i] && w_sent[i]), 64'(1));
        void'(txq[i].pop_front());
        aw_sent[i] = 1'b0;
        w_sent[i]  = 1'b0;
        age[i]     = 0;
        bcnt[i]++;
      end else if (txq[i].size() > 0) begin
        age[i]++;
      end
    end

    if (aw_stall > 0 && s_awvalid) aw_stall--;
    if (w_stall > 0 && s_wvalid) w_stall--;
    if (b_hs) begin
      b_pend = 1'b0;
      has_aw = 1'b0;
      has_w  = 1'b0;
    end else if (b_pend && b_cnt > 0) begin
      b_cnt--;
    end else if (!b_pend && has_aw && has_w) begin
      b_pend = 1'b1;
      b_cnt  = rand_bdly ? int'($urandom_range(0, 3)) : bdelay;
    end

    if (axi_rst) begin
      model_busy = 1'b0;
      model_last = 1'b1;
      has_aw = 1'b0;
      has_w  = 1'b0;
      b_pend = 1'b0;
      for (int i = 0; i < 2; i++) begin
        aw_sent[i] = 1'b0;
        w_sent[i]  = 1'b0;
        age[i]     = 0;
      end
    end else if (model_busy) begin
      if (b_hs) begin
        model_busy = 1'b0;
        model_last = own;
      end
    end else if (m_awvalid != 2'b00) begin
`ifdef AXIL_WR_ARB_FIXED_PRIO_EN
      model_owner = !m_awvalid[0];
`else
      model_owner = (m_awvalid == 2'b11) ? !model_last : m_awvalid[1];
`endif
      model_busy = 1'b1;
      xcyc = -1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    monitor();
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((txq[0].size() > 0 || txq[1].size() > 0 || model_busy || b_pend) && n < maxc) begin
      step();
      n++;
    end
    check("drain_done", 64'(txq[0].size() + txq[1].size() + int'(model_busy) + int'(b_pend)), 64'(0));
    step();
  endtask

  initial begin
    rst_req = 1'b1;
    axi_rst = 1'b1;
    m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0; m_bready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    brand = 0; srand = 0; rand_bdly = 0;
    aw_stall = 0; w_stall = 0; bdelay = 0; b_cnt = 0;
    model_last = 1'b1;
    step();
    step();
    rst_req = 1'b0;
    step();

    // Single m0 write
    push(0, 17'h00010, 32'hDEADBEEF, 4'hF, 2'd0);
    drain(50);
    check("t1_log_size", 64'(slv_log.size()), 64'(1));
    if (slv_log.size() > 0) check("t1_awaddr", 64'(slv_log[0]), 64'h10);
    check("t1_aw_rel", 64'(aw_rel), 64'(0));
    check("t1_w_rel", 64'(w_rel), 64'(0));
    check("t1_bvalid_m0", 64'(bv_cyc[0]), 64'(1));
    check("t1_bvalid_m1", 64'(bv_cyc[1]), 64'(0));

    // Both masters contending, two writes each
    do_reset();
    slv_log.delete();
    push(0, 17'h00100, 32'h11111111, 4'hF, 2'd0);
    push(0, 17'h00104, 32'h22222222, 4'h3, 2'd0);
    push(1, 17'h00200, 32'h33333333, 4'hC, 2'd0);
    push(1, 17'h00204, 32'h44444444, 4'h1, 2'd0);
`ifdef AXIL_WR_ARB_FIXED_PRIO_EN
    exp_ord[0] = 17'h100; exp_ord[1] = 17'h104; exp_ord[2] = 17'h200; exp_ord[3] = 17'h204;
`else
    exp_ord[0] = 17'h100; exp_ord[1] = 17'h200; exp_ord[2] = 17'h104; exp_ord[3] = 17'h204;
`endif
    drain(100);
    check("t2_log_size", 64'(slv_log.size()), 64'(4));
    for (int k = 0; k < 4 && k < slv_log.size(); k++) check("t2_order", 64'(slv_log[k]), 64'(exp_ord[k]));

    // Slave AW stalled 3 cycles, W accepted first
    aw_stall = 3;
    whs0 = whs_cnt;
    push(0, 17'h00300, 32'hCAFEF00D, 4'h5, 2'd0);
    drain(50);
    check("t3_w_rel", 64'(w_rel), 64'(0));
    check("t3_aw_rel", 64'(aw_rel), 64'(3));
    check("t3_w_handshakes", 64'(whs_cnt - whs0), 64'(1));

    // Delayed B while m1 waits
    bdelay = 5;
    slv_log.delete();
    push(0, 17'h00400, 32'h0BADF00D, 4'hF, 2'd0);
    step();
    push(1, 17'h00500, 32'h12345678, 4'hF, 2'd0);
    drain(60);
    bdelay = 0;
    check("t4_log_size", 64'(slv_log.size()), 64'(2));
    if (slv_log.size() == 2) begin
      check("t4_first", 64'(slv_log[0]), 64'h400);
      check("t4_second", 64'(slv_log[1]), 64'h500);
    end

    // Master B backpressure
    bst[0] = 2;
    bv0 = bv_cyc[0];
    push(0, 17'h00600, 32'hA5A5A5A5, 4'hF, 2'd0);
    drain(50);
    check("t5_bvalid_cycles", 64'(bv_cyc[0] - bv0), 64'(3));

    // Reset in the middle of XFER
    aw_stall = 5;
    w_stall = 5;
    push(0, 17'h00700, 32'h5A5A5A5A, 4'hF, 2'd0);
    step();
    step();
    check("t6_in_xfer", 64'(grant), 64'(2'b01));
    aw_stall = 0;
    w_stall = 0;
    do_reset();
    step();
    check("t6_after_rst", 64'(grant), 64'(2'b00));
    step();
    check("t6_regrant", 64'(grant), 64'(2'b01));
    drain(50);

    // Randomized traffic
    do_reset();
    srand = 1; brand = 1; rand_bdly = 1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (txq[i].size() < 3 && $urandom_range(0, 3) == 0)
          push(i, AW'($urandom), DW'($urandom), SW'($urandom), 2'($urandom_range(0, 2)));
      end
      step();
    end
    drain(800);
    srand = 0; brand = 0; rand_bdly = 0;
    check("bcount_m0", 64'(bcnt[0]), 64'(pushed[0]));
    check("bcount_m1", 64'(bcnt[1]), 64'(pushed[1]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
